// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: immediate-extension mode encodings and default widths.
package cpu_pkg;

  localparam int unsigned IMM_W = 16;
  localparam int unsigned XLEN  = 32;

  typedef logic [1:0] ext_mode_t;

  localparam ext_mode_t EXT_ZERO = 2'd0;
  localparam ext_mode_t EXT_SIGN = 2'd1;
  localparam ext_mode_t EXT_LUI  = 2'd2;
  localparam ext_mode_t EXT_BR   = 2'd3;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: zero, sign, upper-immediate and scaled branch offset.
module imm_ext_core
  import cpu_pkg::*;
#(
  parameter int unsigned IN_W     = IMM_W,
  parameter int unsigned OUT_W    = XLEN,
  parameter int unsigned BR_SHIFT = 2
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext
);

  localparam int unsigned PadW = OUT_W - IN_W;

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  always_comb begin
    zext = {{PadW{1'b0}}, imm};
    sext = {{PadW{imm[IN_W-1]}}, imm};
    ext  = '0;
    case (mode)
      EXT_ZERO: ext = zext;
      EXT_SIGN: ext = sext;
      EXT_LUI:  ext = {imm, {PadW{1'b0}}};
      EXT_BR:   ext = sext << BR_SHIFT;
      default:  ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage immediate extension unit with valid/ready flow control, flush and branch target.
module imm_ext_pipe
  import cpu_pkg::*;
#(
  parameter int unsigned IN_W     = IMM_W,
  parameter int unsigned OUT_W    = XLEN,
  parameter int unsigned BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [OUT_W-1:0] in_pc4,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_ext,
  output logic [OUT_W-1:0] out_tgt,
  output logic [1:0]       out_mode
);

  logic             s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]  s1_imm_q, s1_imm_d;
  logic [1:0]       s1_mode_q, s1_mode_d;
  logic [OUT_W-1:0] s1_pc4_q, s1_pc4_d;

  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] s2_ext_q, s2_ext_d;
  logic [OUT_W-1:0] s2_tgt_q, s2_tgt_d;
  logic [1:0]       s2_mode_q, s2_mode_d;

  logic             stage2_adv;
  logic             s1_adv;
  logic             accept;
  logic [OUT_W-1:0] core_ext;

  imm_ext_core #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .BR_SHIFT (BR_SHIFT)
  ) u_core (
    .imm  (s1_imm_q),
    .mode (s1_mode_q),
    .ext  (core_ext)
  );

  always_comb begin
    stage2_adv = !s2_valid_q || out_ready;
    s1_adv     = s1_valid_q && stage2_adv;
    // Flush blocks intake so a beat offered in the kill cycle is never captured.
    in_ready   = !flush && (!s1_valid_q || stage2_adv);
    accept     = in_valid && in_ready;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_imm_d   = s1_imm_q;
    s1_mode_d  = s1_mode_q;
    s1_pc4_d   = s1_pc4_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_imm_d   = in_imm;
      s1_mode_d  = in_mode;
      s1_pc4_d   = in_pc4;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (flush) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_ext_d   = s2_ext_q;
    s2_tgt_d   = s2_tgt_q;
    s2_mode_d  = s2_mode_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_ext_d   = core_ext;
      s2_tgt_d   = (s1_mode_q == EXT_BR) ? s1_pc4_q + core_ext : '0;
      s2_mode_d  = s1_mode_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
    if (flush) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_imm_q   <= '0;
      s1_mode_q  <= '0;
      s1_pc4_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_ext_q   <= '0;
      s2_tgt_q   <= '0;
      s2_mode_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_imm_q   <= s1_imm_d;
      s1_mode_q  <= s1_mode_d;
      s1_pc4_q   <= s1_pc4_d;
      s2_valid_q <= s2_valid_d;
      s2_ext_q   <= s2_ext_d;
      s2_tgt_q   <= s2_tgt_d;
      s2_mode_q  <= s2_mode_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_ext   = s2_ext_q;
  assign out_tgt   = s2_tgt_q;
  assign out_mode  = s2_mode_q;

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Parametrised, pipelined immediate extension unit for the pipelined CPU datapath.
- Takes a raw instruction immediate plus a mode and produces the extended operand.
- For branch mode it also produces the branch target (PC+4 + scaled offset).
- Two register stages with a valid/ready handshake, so it sits between decode and execute and honours stalls and flushes.

Parameters:
IN_W, 16, immediate input width
OUT_W, 32, extended output width and PC width; must satisfy OUT_W > IN_W
BR_SHIFT, 2, left shift applied to the branch offset (word addressing)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept an input beat this cycle
in_imm  in  IN_W  raw immediate
in_mode  in  2  0=ZERO, 1=SIGN, 2=LUI, 3=BR
in_pc4  in  OUT_W  PC+4 of the instruction (used only in BR mode)
flush  in  1  synchronous pipeline kill (branch mispredict / exception)
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts output beat
out_ext  out  OUT_W  extended immediate
out_tgt  out  OUT_W  branch target; 0 unless mode was BR
out_mode  out  2  mode carried alongside the result

Behaviour:
- Reset (rst_n=0, asynchronous):
  - s1_valid, s2_valid = 0.
  - out_ext, out_tgt, out_mode = 0; out_valid = 0.
  - in_ready is combinational and goes high immediately after release.
- Stage 1 (capture) registers in_imm, in_mode and in_pc4 when in_valid && in_ready.
- Stage 2 (compute) registers out_ext, out_tgt and out_mode computed from the stage-1 contents. Latency is exactly 2 cycles from acceptance to out_valid when there is no backpressure.
- Extension rules, with imm the stage-1 immediate and fill = imm[IN_W-1]:
  - ZERO: {(OUT_W-IN_W){0}, imm}.
  - SIGN: {(OUT_W-IN_W){fill}, imm}.
  - LUI: imm << (OUT_W-IN_W), low bits zero; for IN_W=16/OUT_W=32 this is {imm, 16'h0}.
  - BR: ext = SIGN(imm) << BR_SHIFT, truncated to OUT_W; tgt = pc4 + ext modulo 2^OUT_W (wrap-around, no carry-out, no flag).
  - Modes other than BR: out_tgt = 0.
- Handshake:
  - Stage 2 advances when !s2_valid || out_ready.
  - Stage 1 advances into stage 2 when s1_valid && stage2_adv.
  - in_ready = !s1_valid || stage2_adv.
  - Full throughput of 1 beat/cycle when out_ready is held high.
  - While out_valid && !out_ready, out_ext, out_tgt and out_mode hold stable.
  - Producer may hold in_valid low at any time; in_imm is don't-care when !in_valid.
- Flush:
  - On a clock edge with flush=1, s1_valid and s2_valid clear to 0.
  - Any beat offered that cycle is discarded; in_ready is forced to 0 while flush=1.
  - Data registers need not clear.
  - flush has priority over simultaneous accept and advance.
- Simultaneous output consume and input accept with both stages full: all three transfers occur in the same cycle, with no bubble and no loss.
- Reset asserted mid-operation: all in-flight beats are lost and no partial output appears.

Decomposition:
- Shared package cpu_pkg:
  - mode constants EXT_ZERO=2'd0, EXT_SIGN=2'd1, EXT_LUI=2'd2, EXT_BR=2'd3.
  - Default widths IMM_W=16, XLEN=32.
- One combinational sub-module, imm_ext_core: takes imm and mode, returns ext, implementing the four extension rules.
  - Reusable by the single-cycle path.
- The target adder and both pipeline stages stay in imm_ext_pipe.

Test Plan:
- Reset then single beats, out_ready=1:
  - imm=16'h8001 ZERO → out_ext=32'h00008001, 2 cycles after accept.
  - imm=16'h8001 SIGN → 32'hFFFF8001.
  - imm=16'h1234 LUI → 32'h12340000, out_tgt=0.
- BR wrap: pc4=32'h00000004, imm=16'hFFFE → ext=32'hFFFFFFF8, tgt=32'hFFFFFFFC. Then pc4=32'hFFFFFFFC, imm=16'h0002 → tgt=32'h00000004 (wrap-around).
- Backpressure: stream 4 SIGN beats (imm 1..4) with out_ready low for 3 cycles.
  - in_ready drops after 2 beats are accepted.
  - out_ext holds 32'h1 stable while stalled.
  - After release, outputs 1,2,3,4 appear in order with no duplicates.
- Flush: 2 beats in flight plus a third offered with flush=1 → next cycle out_valid=0 and in_ready=1. The third beat never emerges; the following beat emerges normally after 2 cycles.
- Async reset mid-stream: drop rst_n between clock edges with both stages valid → out_valid=0 immediately, out_ext=0; after release, a new beat's result appears after 2 cycles.
- Parameter variant IN_W=12, OUT_W=32, BR_SHIFT=1: imm=12'h800 SIGN → 32'hFFFFF800; BR with pc4=32'h100 → tgt=32'h100+32'hFFFFF000=32'hFFFFF100.
